// File: rtl/alu_shift_pkg.sv
// Shared definitions for the rotate/shift sequencer: op codes, FSM states and
// op-decode helpers (which ops shift right, where the shifted-in bit comes from).
package alu_shift_pkg;

  typedef enum logic [3:0] {
    OP_RLC = 4'd0,
    OP_RRC = 4'd1,
    OP_RL  = 4'd2,
    OP_RR  = 4'd3,
    OP_SLA = 4'd4,
    OP_SRA = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_RLD = 4'd8,
    OP_RRD = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_NIB1 = 3'd2,
    ST_NIB2 = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Source of the bit entering the vacated position of the shifter.
  typedef enum logic [2:0] {
    SIN_ZERO = 3'd0,
    SIN_ONE  = 3'd1,
    SIN_MSB  = 3'd2,
    SIN_LSB  = 3'd3,
    SIN_CF   = 3'd4
  } sin_e;

  // Bit n set when op code n shifts right (RRC, RR, SRA, SRL).
  localparam logic [15:0] RIGHT_OPS = 16'h00AA;

  // Highest op code that goes through the shifter core.
  localparam logic [3:0] LAST_SHIFT_OP = 4'd7;

  function automatic sin_e shift_in_src(input logic [3:0] op);
    case (op)
      OP_RLC, OP_SRA: shift_in_src = SIN_MSB;
      OP_RRC:         shift_in_src = SIN_LSB;
      OP_RL, OP_RR:   shift_in_src = SIN_CF;
      OP_SLL:         shift_in_src = SIN_ONE;
      default:        shift_in_src = SIN_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_flags.sv
// Combinational sign / zero / even-parity flags of an 8-bit value.
module alu_shift_flags (
  input  logic [7:0] v,
  output logic       sf,
  output logic       zf,
  output logic       pf
);

  assign sf = v[7];
  assign zf = (v == 8'h00);
  assign pf = ~^v;

endmodule

// File: rtl/alu_shifter_core.sv
// Combinational one-bit rotate/shift core driven by alu_shift_ctrl.
// Left shifts move db up and insert `in` at bit 0; right shifts insert at bit 7.
// The bit shifted out appears on cy_out. With oe low both outputs are 0.
module alu_shifter_core (
  input  logic [7:0] db,
  input  logic       enable,
  input  logic       right,
  input  logic       in,
  input  logic       oe,
  output logic [7:0] out,
  output logic       cy_out
);

  // Shift when enabled, pass db through otherwise, gate everything with oe.
  always_comb begin
    out    = db;
    cy_out = 1'b0;
    if (enable) begin
      if (right) begin
        out    = {in, db[7:1]};
        cy_out = db[0];
      end else begin
        out    = {db[6:0], in};
        cy_out = db[7];
      end
    end
    if (!oe) begin
      out    = 8'h00;
      cy_out = 1'b0;
    end
  end

endmodule

// File: rtl/alu_shift_ctrl.sv
// Rotate/shift command sequencer in front of alu_shifter_core.
// Accepts one command per handshake, drives the shifter for one EXEC cycle and
// registers result, carry and S/Z/P flags, presented with a one-cycle done.
// Optional feature macro: ALU_SHIFT_RLD_EN enables the two-phase nibble rotates
// RLD/RRD (NIB1/NIB2 states); without it op codes 8/9 behave as illegal codes.
module alu_shift_ctrl
  import alu_shift_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] din,
  input  logic [7:0] acc,
  input  logic       cf_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] acc_out,
  output logic       cf_out,
  output logic       sf,
  output logic       zf,
  output logic       pf,
  output logic [7:0] sh_db,
  output logic       sh_enable,
  output logic       sh_right,
  output logic       sh_in,
  output logic       sh_oe,
  input  logic [7:0] sh_out,
  input  logic       sh_cy
);

  state_e     state, state_nxt;
  logic [3:0] op_q;
  logic [7:0] din_q, acc_q;
  logic       cf_q;
  logic       legal_q, nib_start;
  logic [7:0] exec_res, flag_val;
  logic       exec_cy, sf_nxt, zf_nxt, pf_nxt;

  assign legal_q = (op_q <= LAST_SHIFT_OP);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // Illegal codes bypass the (idle) shifter and keep operand and carry.
  assign exec_res = legal_q ? sh_out : din_q;
  assign exec_cy  = legal_q ? sh_cy  : cf_q;

`ifdef ALU_SHIFT_RLD_EN
  logic       rld_q;
  logic [7:0] nib_res, nib_acc;

  assign nib_start = (op == OP_RLD) || (op == OP_RRD);
  assign rld_q     = (op_q == OP_RLD);
  assign nib_res   = rld_q ? {din_q[3:0], acc_q[3:0]} : {acc_q[3:0], din_q[7:4]};
  assign nib_acc   = rld_q ? {acc_q[7:4], din_q[7:4]} : {acc_q[7:4], din_q[3:0]};
  // Nibble rotates take their flags from the new accumulator.
  assign flag_val  = (state == ST_NIB2) ? nib_acc : exec_res;
`else
  assign nib_start = 1'b0;
  assign flag_val  = exec_res;
`endif

  alu_shift_flags u_flags (
    .v  (flag_val),
    .sf (sf_nxt),
    .zf (zf_nxt),
    .pf (pf_nxt)
  );

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = nib_start ? ST_NIB1 : ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
`ifdef ALU_SHIFT_RLD_EN
      ST_NIB1: state_nxt = ST_NIB2;
      ST_NIB2: state_nxt = ST_DONE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Latch the command operands on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= 4'h0;
      din_q <= 8'h00;
      acc_q <= 8'h00;
      cf_q  <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      op_q  <= op;
      din_q <= din;
      acc_q <= acc;
      cf_q  <= cf_in;
    end
  end

  // Shifter controls are live only during EXEC of a legal shift op.
  always_comb begin
    sh_db     = 8'h00;
    sh_enable = 1'b0;
    sh_right  = 1'b0;
    sh_in     = 1'b0;
    sh_oe     = 1'b0;
    if (state == ST_EXEC && legal_q) begin
      sh_db     = din_q;
      sh_enable = 1'b1;
      sh_oe     = 1'b1;
      sh_right  = RIGHT_OPS[op_q];
      case (shift_in_src(op_q))
        SIN_ONE: sh_in = 1'b1;
        SIN_MSB: sh_in = din_q[7];
        SIN_LSB: sh_in = din_q[0];
        SIN_CF:  sh_in = cf_q;
        default: sh_in = 1'b0;
      endcase
    end
  end

  // Result, accumulator, carry and flags, held from done until the next op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= 8'h00;
      acc_out <= 8'h00;
      cf_out  <= 1'b0;
      sf      <= 1'b0;
      zf      <= 1'b0;
      pf      <= 1'b0;
    end else begin
      case (state)
        ST_EXEC: begin
          result  <= exec_res;
          acc_out <= acc_q;
          cf_out  <= exec_cy;
          sf      <= sf_nxt;
          zf      <= zf_nxt;
          pf      <= pf_nxt;
        end
`ifdef ALU_SHIFT_RLD_EN
        ST_NIB1: result <= nib_res;
        ST_NIB2: begin
          acc_out <= nib_acc;
          cf_out  <= cf_q;
          sf      <= sf_nxt;
          zf      <= zf_nxt;
          pf      <= pf_nxt;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_ctrl.sv
// Bench for alu_shift_ctrl + alu_shifter_core: directed commands with literal
// expectations, plus an arithmetic reference model checked every cycle.
module tb_alu_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op = 4'h0;
  logic [7:0] din = 8'h00;
  logic [7:0] acc = 8'h00;
  logic       cf_in = 1'b0;
  logic       busy, done, cf_out, sf, zf, pf;
  logic [7:0] result, acc_out, sh_db, sh_out;
  logic       sh_enable, sh_right, sh_in, sh_oe, sh_cy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

`ifdef ALU_SHIFT_RLD_EN
  localparam bit NIB_EN = 1'b1;
`else
  localparam bit NIB_EN = 1'b0;
`endif

  alu_shift_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .din(din), .acc(acc),
    .cf_in(cf_in), .busy(busy), .done(done), .result(result), .acc_out(acc_out),
    .cf_out(cf_out), .sf(sf), .zf(zf), .pf(pf), .sh_db(sh_db),
    .sh_enable(sh_enable), .sh_right(sh_right), .sh_in(sh_in), .sh_oe(sh_oe),
    .sh_out(sh_out), .sh_cy(sh_cy)
  );

  alu_shifter_core core (
    .db(sh_db), .enable(sh_enable), .right(sh_right), .in(sh_in), .oe(sh_oe),
    .out(sh_out), .cy_out(sh_cy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bit entering the vacated position, straight from the op table.
  function automatic logic sin_bit(input logic [3:0] o, input logic [7:0] d, input logic c);
    case (o)
      4'd0, 4'd5: return d[7];
      4'd1:       return d[0];
      4'd2, 4'd3: return c;
      4'd6:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference: final outputs of one command, computed arithmetically.
  task automatic model_op(input logic [3:0] o, input logic [7:0] d, input logic [7:0] a,
                          input logic c, output logic [7:0] r, output logic [7:0] ra,
                          output logic rc, output bit nib);
    int di, ai, bi;
    di = int'(d); ai = int'(a); bi = int'(sin_bit(o, d, c));
    r = d; ra = a; rc = c; nib = 1'b0;
    if (o <= 4'd7) begin
      if (o % 2 == 0) begin
        r  = 8'((di * 2 + bi) % 256);
        rc = 1'(di / 128);
      end else begin
        r  = 8'(di / 2 + bi * 128);
        rc = 1'(di % 2);
      end
    end else if (NIB_EN && (o == 4'd8 || o == 4'd9)) begin
      nib = 1'b1;
      if (o == 4'd8) begin
        r  = 8'((di % 16) * 16 + ai % 16);
        ra = 8'((ai / 16) * 16 + di / 16);
      end else begin
        r  = 8'((ai % 16) * 16 + di / 16);
        ra = 8'((ai / 16) * 16 + di % 16);
      end
    end
  endtask

  // Model state: cycles left in the current command and the visible outputs.
  int         m_cnt = 0;
  bit         m_nib = 1'b0;
  logic [3:0] m_op = 4'h0;
  logic [7:0] m_din = 8'h00;
  logic       m_cf = 1'b0;
  logic [7:0] p_res, p_acc;
  logic       p_cf;
  logic [7:0] e_res = 8'h00, e_acc = 8'h00;
  logic       e_cf = 1'b0, e_sf = 1'b0, e_zf = 1'b0, e_pf = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [7:0] v;
    if (reset) begin
      m_cnt = 0; m_nib = 1'b0; m_op = 4'h0; m_din = 8'h00; m_cf = 1'b0;
      e_res = 8'h00; e_acc = 8'h00; e_cf = 1'b0; e_sf = 1'b0; e_zf = 1'b0; e_pf = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_op = op; m_din = din; m_cf = cf_in;
        model_op(op, din, acc, cf_in, p_res, p_acc, p_cf, m_nib);
        m_cnt = m_nib ? 3 : 2;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        e_res = p_res; e_acc = p_acc; e_cf = p_cf;
        v = m_nib ? p_acc : p_res;
        e_sf = (v >= 8'd128);
        e_zf = (v == 8'd0);
        e_pf = ($countones(v) % 2 == 0);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic x_exec;
    chk("busy", 32'(busy), 32'(m_cnt > 0));
    chk("done", 32'(done), 32'(m_cnt == 1));
    if (done) done_cnt++;
    x_exec = (m_cnt == 2) && !m_nib && (m_op <= 4'd7);
    chk("sh_db", 32'(sh_db), x_exec ? 32'(m_din) : 32'd0);
    chk("sh_enable", 32'(sh_enable), 32'(x_exec));
    chk("sh_oe", 32'(sh_oe), 32'(x_exec));
    chk("sh_right", 32'(sh_right), 32'(x_exec && (m_op % 2 == 1)));
    chk("sh_in", 32'(sh_in), 32'(x_exec && sin_bit(m_op, m_din, m_cf)));
    if (m_cnt <= 1) begin
      chk("result", 32'(result), 32'(e_res));
      chk("acc_out", 32'(acc_out), 32'(e_acc));
      chk("cf_out", 32'(cf_out), 32'(e_cf));
      chk("sf", 32'(sf), 32'(e_sf));
      chk("zf", 32'(zf), 32'(e_zf));
      chk("pf", 32'(pf), 32'(e_pf));
    end
  end

  // One command with hand-computed results; returns at the negedge of done.
  task automatic run_op(input logic [3:0] o, input logic [7:0] d, input logic [7:0] a,
                        input logic c, input logic [7:0] er, input logic [7:0] ea,
                        input logic ec, input logic [2:0] eszp, input int elat,
                        input string nm);
    int n;
    bit seen;
    @(negedge clk);
    op = o; din = d; acc = a; cf_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(n), 32'(elat));
      chk({nm, "_result"}, 32'(result), 32'(er));
      chk({nm, "_acc_out"}, 32'(acc_out), 32'(ea));
      chk({nm, "_cf"}, 32'(cf_out), 32'(ec));
      chk({nm, "_szp"}, 32'({sf, zf, pf}), 32'(eszp));
    end
  endtask

  initial begin
    int dc;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outputs", 32'({result, acc_out, cf_out, sf, zf, pf}), 32'd0);
    chk("reset_sh", 32'({sh_db, sh_enable, sh_right, sh_in, sh_oe}), 32'd0);
    #2 reset = 1'b0;

    run_op(4'd0, 8'h85, 8'h00, 1'b0, 8'h0B, 8'h00, 1'b1, 3'b000, 2, "rlc");
    run_op(4'd3, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 3'b011, 2, "rr");
    run_op(4'd5, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b1, 3'b101, 2, "sra");
    run_op(4'd6, 8'h40, 8'h00, 1'b0, 8'h81, 8'h00, 1'b0, 3'b101, 2, "sll");
    run_op(4'd1, 8'h01, 8'h5A, 1'b0, 8'h80, 8'h5A, 1'b1, 3'b100, 2, "rrc");
    run_op(4'd2, 8'h80, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 3'b000, 2, "rl");
    run_op(4'd4, 8'hFF, 8'h00, 1'b0, 8'hFE, 8'h00, 1'b1, 3'b100, 2, "sla");
    run_op(4'd7, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 3'b011, 2, "srl");
    run_op(4'd8, 8'h34, 8'h12, 1'b1, NIB_EN ? 8'h42 : 8'h34, NIB_EN ? 8'h13 : 8'h12,
           1'b1, 3'b000, NIB_EN ? 3 : 2, "rld");
    run_op(4'd9, 8'h34, 8'h12, 1'b0, NIB_EN ? 8'h23 : 8'h34, NIB_EN ? 8'h14 : 8'h12,
           1'b0, NIB_EN ? 3'b001 : 3'b000, NIB_EN ? 3 : 2, "rrd");
    run_op(4'd12, 8'h5A, 8'h77, 1'b1, 8'h5A, 8'h77, 1'b1, 3'b001, 2, "illegal");

    // start pulsed during EXEC and DONE must be ignored
    @(negedge clk);
    op = 4'd7; din = 8'h01; cf_in = 1'b0; start = 1'b1;
    #1 dc = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 4'd0; din = 8'hFF;
    @(negedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1 chk("ign_done_count", 32'(done_cnt - dc), 32'd1);

    // start held high: re-accepted in the idle cycle after DONE
    @(negedge clk);
    op = 4'd6; din = 8'h40; cf_in = 1'b0; start = 1'b1;
    #1 dc = done_cnt;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #1 chk("held_done_count", 32'(done_cnt - dc), 32'd2);
    chk("held_result", 32'(result), 32'h81);
    repeat (2) @(negedge clk);

    // reset during EXEC aborts and clears
    op = 4'd1; din = 8'h01; acc = 8'h33; cf_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({result, acc_out, cf_out, sf, zf, pf}), 32'd0);
    chk("rst_mid_ctrl", 32'({busy, done}), 32'd0);
    chk("rst_mid_sh", 32'({sh_db, sh_enable, sh_right, sh_in, sh_oe}), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 dc = done_cnt;
    repeat (4) @(negedge clk);
    #1 chk("rst_mid_no_done", 32'(done_cnt - dc), 32'd0);
    run_op(4'd5, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b1, 3'b101, 2, "sra_after_rst");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
